// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared state encoding and default widths for the frequency measurement controller
package freq_meas_pkg;

    localparam int GATE_W_DEF = 16;
    localparam int CNT_W_DEF  = 10;
    localparam int SETTLE_DEF = 4;

    // Binary encoding: all four codes are legal states, so nothing else is reachable.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GATE    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// rtl/freq_meas_ctrl_if.sv - control/result bundle; FREQ_MEAS_CONTINUOUS_EN adds the cont request
interface freq_meas_ctrl_if
    import freq_meas_pkg::*;
#(
    parameter int GATE_W = GATE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
`ifdef FREQ_MEAS_CONTINUOUS_EN
    logic              cont;
`endif
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic [CNT_W-1:0]  cnt_in;
    logic              enable;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic              err_len;

    modport master (
`ifdef FREQ_MEAS_CONTINUOUS_EN
        output cont,
`endif
        output start, abort, gate_len, cnt_in,
        input  enable, busy, result, result_valid, err_len
    );

    modport slave (
`ifdef FREQ_MEAS_CONTINUOUS_EN
        input  cont,
`endif
        input  start, abort, gate_len, cnt_in,
        output enable, busy, result, result_valid, err_len
    );

endinterface

// File: rtl/freq_meas_ctrl_gate_timer.sv
// rtl/freq_meas_ctrl_gate_timer.sv - loadable saturating down-counter timing both the gate and settle windows
module gate_timer
    import freq_meas_pkg::*;
#(
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [GATE_W-1:0] load_val_i,
    output logic              tc_o
);

    logic [GATE_W-1:0] cnt_q;
    logic [GATE_W-1:0] cnt_d;

    // Holds at zero rather than wrapping, so a maximum-length load never rolls over.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/freq_meas_ctrl.sv
// rtl/freq_meas_ctrl.sv - gated frequency measurement controller; FREQ_MEAS_CONTINUOUS_EN enables back-to-back windows
module freq_meas_ctrl
    import freq_meas_pkg::*;
#(
    parameter int GATE_W = GATE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    freq_meas_ctrl_if.slave bus
);

    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE - 1);

    state_e            state_q;
    state_e            state_d;
    logic [GATE_W-1:0] len_q;
    logic [GATE_W-1:0] len_d;
    logic [CNT_W-1:0]  result_q;
    logic [CNT_W-1:0]  result_d;
    logic              err_q;
    logic              err_d;
    logic              tmr_load;
    logic [GATE_W-1:0] tmr_val;
    logic              tmr_tc;
    logic              cont;

`ifdef FREQ_MEAS_CONTINUOUS_EN
    assign cont = bus.cont;
`else
    assign cont = 1'b0;
`endif

    gate_timer #(.GATE_W(GATE_W)) u_gate_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Timer loads with length-1 so the terminal count lands on the last cycle of each window.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        result_d = result_q;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.gate_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_GATE;
                        len_d    = bus.gate_len;
                        tmr_load = 1'b1;
                        tmr_val  = bus.gate_len - 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_tc) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_tc) begin
                    // Capture on entry so result is already updated while result_valid is shown.
                    state_d  = ST_CAPTURE;
                    result_d = bus.cnt_in;
                end
            end
            ST_CAPTURE: begin
                if (!bus.abort && cont) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = len_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.enable       = (state_q == ST_GATE);
        bus.busy         = (state_q != ST_IDLE);
        bus.result_valid = (state_q == ST_CAPTURE);
        bus.result       = result_q;
        bus.err_len      = err_q;
    end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb/tb_freq_meas_ctrl.sv - randomized self-checking bench for freq_meas_ctrl against a cycle-schedule model
module tb_freq_meas_ctrl;
    import freq_meas_pkg::*;

    localparam int GW = GATE_W_DEF;
    localparam int CW = CNT_W_DEF;
    localparam int S  = SETTLE_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_result = '0;

    freq_meas_ctrl_if #(.GATE_W(GW), .CNT_W(CW)) bus ();

    freq_meas_ctrl #(.GATE_W(GW), .CNT_W(CW), .SETTLE(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".enable"}, 32'(bus.enable), 32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, ".result"}, 32'(bus.result), 32'(exp_result));
        check({tag, ".err_len"}, 32'(bus.err_len), 32'd0);
    endtask

    // Model: after the accepting edge, cycle k=1..g has enable high, k=g+1..g+S is settle,
    // k=g+S+1 shows result_valid with the cnt_in driven during cycle g+S.
    task automatic measure(input int g, input int abort_k, input int restart_k, input int cnt_fix);
        int            total;
        logic [CW-1:0] cap;
        total = g + S + 1;
        cap = exp_result;
        bus.abort = 1'b0;
        bus.start = 1'b1;
        bus.gate_len = GW'(g);
        tick();
        bus.start = 1'b0;
        bus.gate_len = GW'($urandom);
        for (int k = 1; k <= total; k++) begin
            check("enable", 32'(bus.enable), 32'(k <= g));
            check("busy", 32'(bus.busy), 32'd1);
            check("result_valid", 32'(bus.result_valid), 32'(k == total));
            check("result", 32'(bus.result), 32'((k == total) ? cap : exp_result));
            check("err_len", 32'(bus.err_len), 32'd0);
            bus.cnt_in = (cnt_fix >= 0) ? CW'(cnt_fix) : CW'($urandom);
            if (k == g + S) cap = bus.cnt_in;
            bus.abort = (k == abort_k);
            if (k == restart_k) begin
                bus.start = 1'b1;
                bus.gate_len = GW'(3);
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (k == abort_k) begin
                bus.abort = 1'b0;
                bus.start = 1'b0;
                check_idle("abort");
                return;
            end
        end
        bus.start = 1'b0;
        exp_result = cap;
        check_idle("done");
    endtask

    task automatic zero_len_start();
        bus.start = 1'b1;
        bus.gate_len = '0;
        tick();
        bus.start = 1'b0;
        check("err_len.pulse", 32'(bus.err_len), 32'd1);
        check("err_len.busy", 32'(bus.busy), 32'd0);
        check("err_len.enable", 32'(bus.enable), 32'd0);
        tick();
        check_idle("err_len.after");
    endtask

    task automatic abort_with_start(input int g);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.gate_len = GW'(g);
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("abort_start");
        tick();
        check_idle("abort_start.after");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.gate_len = '0;
        bus.cnt_in = '0;
`ifdef FREQ_MEAS_CONTINUOUS_EN
        bus.cont = 1'b0;
`endif
        #2;
        check_idle("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        measure(5, 0, 0, 37);
        check("directed.result37", 32'(bus.result), 32'd37);
        zero_len_start();
        abort_with_start(5);
        abort_with_start(0);
        measure(100, 50, 0, -1);
        measure(100, 0, 20, -1);

        // Reset during the settle window of a 5-cycle gate.
        bus.start = 1'b1;
        bus.gate_len = GW'(5);
        bus.cnt_in = CW'(11);
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        check("pre_rst.enable", 32'(bus.enable), 32'd0);
        check("pre_rst.busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_result = '0;
        check_idle("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("after_rst");
        measure(1, 0, 0, -1);

`ifdef FREQ_MEAS_CONTINUOUS_EN
        begin
            logic [CW-1:0] nxt;
            nxt = exp_result;
            bus.cont = 1'b1;
            bus.start = 1'b1;
            bus.gate_len = GW'(4);
            tick();
            bus.start = 1'b0;
            for (int k = 1; k <= 27; k++) begin
                check("cont.enable", 32'(bus.enable), 32'(((k - 1) % 9) < 4));
                check("cont.busy", 32'(bus.busy), 32'd1);
                check("cont.result_valid", 32'(bus.result_valid), 32'((k % 9) == 0));
                if ((k % 9) == 0) exp_result = nxt;
                check("cont.result", 32'(bus.result), 32'(exp_result));
                bus.cnt_in = CW'($urandom);
                if ((k % 9) == 8) nxt = bus.cnt_in;
                if (k == 19) bus.cont = 1'b0;
                tick();
            end
            check_idle("cont.stop");
        end
`endif

        for (int i = 0; i < 30; i++) begin
            int g;
            int mode;
            g = int'($urandom_range(1, 30));
            mode = int'($urandom_range(0, 4));
            case (mode)
                1: measure(g, int'($urandom_range(1, g + S)), 0, -1);
                2: measure(g, 0, int'($urandom_range(1, g + S + 1)), -1);
                3: zero_len_start();
                4: abort_with_start(int'($urandom_range(0, 9)));
                default: measure(g, 0, 0, -1);
            endcase
            repeat ($urandom_range(0, 3)) begin
                tick();
                check_idle("gap");
            end
        end

        measure((1 << GW) - 1, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 Parameter GATE_W, 16, width of the gate-length counter and of gate_len.
REQ-002 Parameter CNT_W, 10, width of the count result; SHALL match the counter datapath width.
REQ-003 Parameter SETTLE, 4, number of clk cycles enable is held low before capture; legal range 3..15.
REQ-004 clk  input  1  reference clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request for one measurement.
REQ-007 abort  input  1  cancels any measurement in progress.
REQ-008 gate_len  input  GATE_W  gate window length in clk cycles, sampled on accepted start.
REQ-009 cnt_in  input  CNT_W  count value from the counter datapath.
REQ-010 enable  output  1  gate to the counter datapath.
REQ-011 busy  output  1  measurement in progress.
REQ-012 result  output  CNT_W  last captured count.
REQ-013 result_valid  output  1  one-cycle pulse marking a new result.
REQ-014 err_len  output  1  one-cycle pulse: start rejected because gate_len==0.

Function
REQ-015 FSM states SHALL be IDLE, GATE, SETTLE, CAPTURE, one-hot or binary, with no other reachable state.
REQ-016 IDLE: enable=0, busy=0; start=1 with gate_len!=0 and abort=0 SHALL latch gate_len and go to GATE.
REQ-017 IDLE: start=1 with gate_len==0 SHALL stay in IDLE and pulse err_len for exactly one cycle.
REQ-018 Start accepted at edge t0: enable SHALL be high for exactly gate_len cycles starting at t0+1.
REQ-019 GATE: after gate_len cycles, go to SETTLE; enable=0 for exactly SETTLE cycles.
REQ-020 CAPTURE: at edge t0+1+gate_len+SETTLE, result<=cnt_in and result_valid=1 for exactly that one cycle; then IDLE.
REQ-021 busy SHALL be high from t0+1 through the result_valid cycle inclusive.
REQ-022 start SHALL be ignored while busy; the latched gate_len SHALL NOT change mid-measurement.
REQ-023 abort=1 in GATE/SETTLE/CAPTURE SHALL force IDLE next edge: enable=0, no result_valid, result unchanged.
REQ-024 abort and start in the same IDLE cycle: abort wins, start discarded, err_len not pulsed.
REQ-025 gate_len=2^GATE_W-1 SHALL produce exactly that many enable cycles; the gate counter SHALL NOT wrap.
REQ-026 Counter overflow of cnt_in is not detected; result SHALL be the raw captured value.

Reset
REQ-027 rst_n low SHALL force IDLE, enable=0, busy=0, result=0, result_valid=0, err_len=0, latched length=0.
REQ-028 Reset mid-GATE SHALL drop enable asynchronously; measurement restarts only on a new start.

Configuration
REQ-029 Macro FREQ_MEAS_CONTINUOUS_EN: when defined, adds input port cont (1 bit).
REQ-030 With macro and cont=1 at CAPTURE: next state SHALL be GATE with the latched gate_len, busy held high, no start needed.
REQ-031 With macro and cont=0, or without macro: behaviour SHALL be one-shot per REQ-020; without macro, port cont SHALL NOT exist.

Structure
REQ-032 Shared package/include freq_meas_pkg SHALL hold state encodings and default GATE_W, CNT_W, SETTLE.
REQ-033 One sub-module gate_timer (loadable down-counter, GATE_W bits, terminal-count output) SHALL time both GATE and SETTLE.

Verification
REQ-034 gate_len=5, start pulse, cnt_in=10'd37 -> enable high 5 cycles; result=37, result_valid at t0+10 (SETTLE=4).
REQ-035 gate_len=0, start -> err_len one cycle, busy stays 0, enable stays 0.
REQ-036 gate_len=100, abort at cycle 50 -> enable low next edge, no result_valid, previous result retained.
REQ-037 start re-pulsed during GATE with gate_len changed to 3 -> ignored, gate length remains 100.
REQ-038 rst_n low mid-SETTLE -> all outputs 0 immediately; subsequent start with gate_len=1 gives 1 enable cycle.
REQ-039 FREQ_MEAS_CONTINUOUS_EN, cont=1, gate_len=4 -> back-to-back windows, result_valid every 9 cycles, busy continuously high.
